// File: rtl/hk_const_store.sv
// H/K constant store: copies initial-hash words and round constants from an external ROM
// into local RAM after reset, then serves registered reads. HK_CHECKSUM_EN adds a checksum pass.
module hk_const_store #(
    parameter int DW           = 32,
    parameter int H_DEPTH      = 8,
    parameter int K_DEPTH      = 64,
    parameter int ROM_AW       = 13,
    parameter int H_ROM_BASE   = 0,
    parameter int K_ROM_BASE   = 8,
    parameter int SUM_ROM_ADDR = 72
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic [ROM_AW-1:0]          rom_addr,
    input  logic [DW-1:0]              rom_data,
    output logic                       rdy,
    output logic                       err,
    input  logic                       rd_en,
    input  logic                       rd_sel,
    input  logic [$clog2(K_DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]              rd_data,
    output logic                       rd_valid,
    output logic                       rd_err
);
    // state   | meaning
    // S_COPY  | copying ROM words into RAM, two edges per word
    // S_CHECK | fetching and comparing the checksum word (HK_CHECKSUM_EN only)
    // S_READY | store loaded, reads accepted
    // S_FAIL  | checksum mismatch, err held until RST (HK_CHECKSUM_EN only)
    localparam int N   = H_DEPTH + K_DEPTH;
    localparam int IW  = $clog2(N + 1);
    localparam int AW  = $clog2(N);
    localparam int RAW = $clog2(K_DEPTH);

    localparam logic [IW-1:0]     IDX_H     = IW'(H_DEPTH);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(N - 1);
    localparam logic [ROM_AW-1:0] H_BASE_A  = ROM_AW'(H_ROM_BASE);
    localparam logic [ROM_AW-1:0] K_BASE_A  = ROM_AW'(K_ROM_BASE);
    localparam logic [RAW:0]      RD_H_LIM  = (RAW + 1)'(H_DEPTH);
    localparam logic [RAW:0]      RD_K_LIM  = (RAW + 1)'(K_DEPTH);
    localparam logic [AW-1:0]     MEM_K_OFS = AW'(H_DEPTH);

`ifdef HK_CHECKSUM_EN
    localparam logic [ROM_AW-1:0] SUM_A = ROM_AW'(SUM_ROM_ADDR);
    typedef enum logic [1:0] {S_COPY, S_READY, S_CHECK, S_FAIL} state_t;
`else
    typedef enum logic {S_COPY, S_READY} state_t;
`endif
    typedef enum logic {PH_FETCH, PH_WRITE} phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            rdy_q, rdy_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_err_q, rd_err_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            mem_we;
    logic [AW-1:0]   rd_idx;
    logic            rd_in_range;
    logic            rd_hit;
`ifdef HK_CHECKSUM_EN
    logic [DW-1:0]   sum_q, sum_d;
    logic            err_q, err_d;
`endif

    logic [DW-1:0] mem [N];

    always_comb begin
        if (idx_q < IDX_H) begin
            rom_addr = H_BASE_A + ROM_AW'(idx_q);
        end else begin
            rom_addr = K_BASE_A + ROM_AW'(idx_q - IDX_H);
        end
`ifdef HK_CHECKSUM_EN
        if (state_q == S_CHECK) begin
            rom_addr = SUM_A;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        rdy_d   = rdy_q;
        mem_we  = 1'b0;
`ifdef HK_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_COPY: begin
                if (phase_q == PH_FETCH) begin
                    phase_d = PH_WRITE;
                end else begin
                    mem_we  = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    phase_d = PH_FETCH;
`ifdef HK_CHECKSUM_EN
                    sum_d   = sum_q + rom_data;
                    if (idx_q == IDX_LAST) state_d = S_CHECK;
`else
                    if (idx_q == IDX_LAST) begin
                        state_d = S_READY;
                        rdy_d   = 1'b1;
                    end
`endif
                end
            end
`ifdef HK_CHECKSUM_EN
            S_CHECK: begin
                if (phase_q == PH_FETCH) begin
                    phase_d = PH_WRITE;
                end else begin
                    phase_d = PH_FETCH;
                    if (rom_data == sum_q) begin
                        state_d = S_READY;
                        rdy_d   = 1'b1;
                    end else begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
`endif
            S_READY: begin
                state_d = S_READY;
            end
        endcase
    end

    // Reads are gated on the registered rdy, so a request on the edge that raises rdy is rejected.
    always_comb begin
        rd_idx      = rd_sel ? (MEM_K_OFS + AW'(rd_addr)) : AW'(rd_addr);
        rd_in_range = rd_sel ? ({1'b0, rd_addr} < RD_K_LIM) : ({1'b0, rd_addr} < RD_H_LIM);
        rd_hit      = rd_en && rdy_q && rd_in_range;
        rd_valid_d  = rd_hit;
        rd_err_d    = rd_en && !rd_hit;
        rd_data_d   = rd_data_q;
        if (rd_hit) begin
            rd_data_d = mem[rd_idx];
        end else if (rd_en) begin
            rd_data_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_COPY;
            phase_q    <= PH_FETCH;
            idx_q      <= '0;
            rdy_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
`ifdef HK_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            rdy_q      <= rdy_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
`ifdef HK_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

    // RAM contents survive reset; the copy simply rewrites them.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx_q[AW-1:0]] <= rom_data;
        end
    end

    assign rdy      = rdy_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
`ifdef HK_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_hk_const_store.sv
// Scoreboard bench for hk_const_store: random reads against a ROM-derived reference of H/K,
// including reads during copy, at the rdy boundary, and across a mid-copy reset.
module tb_hk_const_store;
    localparam int DW           = 32;
    localparam int H_DEPTH      = 8;
    localparam int K_DEPTH      = 64;
    localparam int ROM_AW       = 13;
    localparam int H_ROM_BASE   = 0;
    localparam int K_ROM_BASE   = 8;
    localparam int SUM_ROM_ADDR = 72;
    localparam int N            = H_DEPTH + K_DEPTH;
    localparam int RAW          = $clog2(K_DEPTH);
    localparam int ROM_SZ       = 128;
`ifdef HK_CHECKSUM_EN
    localparam int READY_EDGE   = 2 * N + 2;
`else
    localparam int READY_EDGE   = 2 * N;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [ROM_AW-1:0] rom_addr;
    logic [DW-1:0]     rom_data = '0;
    logic              rdy, err;
    logic              rd_en = 1'b0;
    logic              rd_sel = 1'b0;
    logic [RAW-1:0]    rd_addr = '0;
    logic [DW-1:0]     rd_data;
    logic              rd_valid, rd_err;

    always #5 CLK = ~CLK;

    hk_const_store #(
        .DW(DW), .H_DEPTH(H_DEPTH), .K_DEPTH(K_DEPTH), .ROM_AW(ROM_AW),
        .H_ROM_BASE(H_ROM_BASE), .K_ROM_BASE(K_ROM_BASE), .SUM_ROM_ADDR(SUM_ROM_ADDR)
    ) dut (
        .CLK(CLK), .RST(RST), .rom_addr(rom_addr), .rom_data(rom_data),
        .rdy(rdy), .err(err), .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err)
    );

    logic [DW-1:0] rom_mem [ROM_SZ];

    always @(posedge CLK) begin
        rom_data <= (rom_addr < ROM_AW'(ROM_SZ)) ? rom_mem[rom_addr[6:0]] : '0;
    end

    // Edges since reset release and whether the last edge saw reset.
    int   rel = 0;
    logic rst_seen = 1'b1;
    always @(posedge CLK) begin
        rst_seen <= RST;
        rel      <= RST ? 0 : rel + 1;
    end

    typedef struct {
        int            due;
        logic          valid;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model_last = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t rel=%0d", nm, act, exp, $time, rel);
        end
    endtask

    task automatic note_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: at t=%0t rel=%0d", nm, $time, rel);
    endtask

    function automatic logic [DW-1:0] ref_word(input logic sel, input int addr);
        return sel ? rom_mem[K_ROM_BASE + addr] : rom_mem[H_ROM_BASE + addr];
    endfunction

    task automatic load_rom(input bit randomize);
        for (int a = 0; a < ROM_SZ; a++) begin
            rom_mem[a] = randomize ? DW'($urandom) : DW'(a) * 32'h01010101;
        end
`ifdef HK_CHECKSUM_EN
        begin
            logic [DW-1:0] s;
            s = '0;
            for (int i = 0; i < H_DEPTH; i++) s += rom_mem[H_ROM_BASE + i];
            for (int j = 0; j < K_DEPTH; j++) s += rom_mem[K_ROM_BASE + j];
            rom_mem[SUM_ROM_ADDR] = s;
        end
`endif
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (rst_seen) begin
            sbq.delete();
            model_last = '0;
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rd_err", rd_err, 0);
            check("rst_rd_data", rd_data, 0);
            check("rst_rdy", rdy, 0);
            check("rst_err", err, 0);
        end else begin
            check("rdy", rdy, rel >= READY_EDGE);
            check("err", err, 0);
            if (rd_valid || rd_err) begin
                if (sbq.size() == 0) begin
                    note_fail("spurious_output");
                end else begin
                    e = sbq.pop_front();
                    check("resp_cycle", rel, e.due);
                    check("rd_valid", rd_valid, e.valid);
                    check("rd_err", rd_err, e.err);
                    check("rd_data", rd_data, e.data);
                    model_last = e.data;
                end
            end else begin
                if (sbq.size() > 0 && sbq[0].due <= rel) begin
                    note_fail("missing_output");
                    void'(sbq.pop_front());
                end
                check("rd_data_hold", rd_data, model_last);
            end
        end
    end

    // Driver: one cycle of stimulus applied at the falling edge.
    task automatic cyc(input bit rst, input bit en, input bit sel, input int addr);
        exp_t e;
        @(negedge CLK);
        RST     = rst;
        rd_en   = en;
        rd_sel  = sel;
        rd_addr = RAW'(addr);
        if (en && !rst) begin
            e.due = rel + 1;
            if (rel >= READY_EDGE && (sel ? addr < K_DEPTH : addr < H_DEPTH)) begin
                e.valid = 1'b1;
                e.err   = 1'b0;
                e.data  = ref_word(sel, addr);
            end else begin
                e.valid = 1'b0;
                e.err   = 1'b1;
                e.data  = '0;
            end
            sbq.push_back(e);
        end
    endtask

    task automatic rnd_cyc();
        cyc(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, K_DEPTH - 1)));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        load_rom(0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // Reads during the copy, ending with one sampled on the edge that raises rdy.
        cyc(0, 1, 0, 8);
        repeat (READY_EDGE - 2) rnd_cyc();
        cyc(0, 1, 1, 5);
        cyc(0, 1, 1, 63);
        cyc(0, 1, 0, 8);
        cyc(0, 1, 0, 7);
        cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        repeat (300) rnd_cyc();

        // New ROM contents, reset mid-copy at edge 60, then a full reload.
        load_rom(1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (59) rnd_cyc();
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        repeat (READY_EDGE - 1) rnd_cyc();
        cyc(0, 1, 1, 63);
        cyc(0, 1, 1, 63);
        repeat (300) rnd_cyc();

        repeat (3) cyc(0, 0, 0, 0);
        check("queue_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
